// File: rtl/adder_seq.sv
// Multi-cycle adder/subtractor: processes one CHUNK-bit slice per cycle with a
// registered inter-slice carry, and produces OF/SF/ZF/CF/cout when the last slice completes.
module adder_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             OF,
    output logic             SF,
    output logic             ZF,
    output logic             CF,
    output logic             cout
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [KW-1:0]    k;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] br;
    logic             sub_r;
    logic             carry;

    logic             c0;
    logic [WIDTH-1:0] b_in;
    int unsigned      lo;
    logic [CHUNK-1:0] xs;
    logic [CHUNK-1:0] bs;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] f_n;
    logic             c_msb;
    logic             last;

    // Initial carry and conditioned second operand for the accept edge.
    always_comb begin
        c0   = op[1] ? (cin ^ op[0]) : op[0];
        b_in = op[0] ? ~y : y;
    end

    // Slice adder; c_msb recovers the carry into the top bit of the slice.
    always_comb begin
        lo    = 32'(k) * CHUNK;
        xs    = CHUNK'(xr >> lo);
        bs    = CHUNK'(br >> lo);
        sum   = {1'b0, xs} + {1'b0, bs} + (CHUNK + 1)'(carry);
        c_msb = xs[CHUNK-1] ^ bs[CHUNK-1] ^ sum[CHUNK-1];
        f_n   = (f & ~(WIDTH'({CHUNK{1'b1}}) << lo)) | (WIDTH'(sum[CHUNK-1:0]) << lo);
        last  = (k == KLAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath, flags and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k         <= '0;
            xr        <= '0;
            br        <= '0;
            sub_r     <= 1'b0;
            carry     <= 1'b0;
            f         <= '0;
            OF        <= 1'b0;
            SF        <= 1'b0;
            ZF        <= 1'b0;
            CF        <= 1'b0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr    <= x;
                        br    <= b_in;
                        sub_r <= op[0];
                        carry <= c0;
                        k     <= '0;
                    end
                end
                RUN: begin
                    f     <= f_n;
                    carry <= sum[CHUNK];
                    if (last) begin
                        cout <= sum[CHUNK];
                        CF   <= sum[CHUNK] ^ sub_r;
                        OF   <= c_msb ^ sum[CHUNK];
                        SF   <= f_n[WIDTH-1];
                        ZF   <= (f_n == '0);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq.sv
// Directed bench for adder_seq: 32/8 main instance plus 16/16 and 12/4 parameter variants.
module tb_adder_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Main instance, WIDTH=32 CHUNK=8
    logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [31:0] x = '0, y = '0;
    logic [1:0]  op = '0;
    logic        in_ready, out_valid, OF, SF, ZF, CF, cout;
    logic [31:0] f;

    adder_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .OF(OF), .SF(SF), .ZF(ZF), .CF(CF), .cout(cout)
    );

    // Single-slice instance, WIDTH=16 CHUNK=16
    logic        iv16 = 1'b0, cin16 = 1'b0;
    logic [15:0] x16 = '0, y16 = '0;
    logic [1:0]  op16 = '0;
    logic        ir16, ov16, of16, sf16, zf16, cf16, co16;
    logic [15:0] f16;

    adder_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .x(x16), .y(y16), .op(op16), .cin(cin16), .out_valid(ov16), .out_ready(1'b1),
        .f(f16), .OF(of16), .SF(sf16), .ZF(zf16), .CF(cf16), .cout(co16)
    );

    // Odd-width instance, WIDTH=12 CHUNK=4
    logic        iv12 = 1'b0, cin12 = 1'b0;
    logic [11:0] x12 = '0, y12 = '0;
    logic [1:0]  op12 = '0;
    logic        ir12, ov12, of12, sf12, zf12, cf12, co12;
    logic [11:0] f12;

    adder_seq #(.WIDTH(12), .CHUNK(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv12), .in_ready(ir12),
        .x(x12), .y(y12), .op(op12), .cin(cin12), .out_valid(ov12), .out_ready(1'b1),
        .f(f12), .OF(of12), .SF(sf12), .ZF(zf12), .CF(cf12), .cout(co12)
    );

    // Issue one op on the main instance; returns edges from accept to out_valid.
    task automatic run_main(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic c, output int lat);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1; op = o; x = a; y = b; cin = c;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        n_chk++;
        if (lat == 0 || w >= 20) begin
            n_fail++;
            $display("FAIL run_main_timeout: in_ready_wait=%0d lat=%0d required completion within 20", w, lat);
        end
    endtask

    task automatic release_main();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if ({in_ready, out_valid, f, OF, SF, ZF, CF, cout} !== {1'b1, 1'b0, 32'h0, 5'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b f=%h flags=%b%b%b%b%b required rdy=1 vld=0 f=0 flags=0",
                     in_ready, out_valid, f, OF, SF, ZF, CF, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_wrap();
        int lat;
        run_main(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        n_chk++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL add_wrap_latency: got %0d required 4", lat);
        end
        n_chk++;
        if ({f, OF, SF, ZF, CF, cout} !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL add_wrap: f=%h OF=%b SF=%b ZF=%b CF=%b cout=%b required f=0 OF=0 SF=0 ZF=1 CF=1 cout=1",
                     f, OF, SF, ZF, CF, cout);
        end
        release_main();
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL out_handshake: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; x = 32'h1111_1111; y = 32'h1111_1111; cin = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if ({in_ready, out_valid, f, OF, SF, ZF, CF, cout} !== {1'b1, 1'b0, 32'h0, 5'b0}) begin
            n_fail++;
            $display("FAIL reset_midrun: rdy=%b vld=%b f=%h flags=%b%b%b%b%b required rdy=1 vld=0 f=0 flags=0",
                     in_ready, out_valid, f, OF, SF, ZF, CF, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_main(2'b00, 32'd1, 32'd2, 1'b0, lat);
        n_chk++;
        if (f !== 32'd3 || ZF !== 1'b0 || CF !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_add: f=%h ZF=%b CF=%b required f=3 ZF=0 CF=0", f, ZF, CF);
        end
        release_main();
    endtask

    task automatic test_sub();
        int lat;
        run_main(2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, lat);
        n_chk++;
        if ({f, OF, SF, ZF, CF, cout} !== {32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_overflow: f=%h OF=%b SF=%b ZF=%b CF=%b cout=%b required f=7fffffff OF=1 SF=0 ZF=0 CF=0 cout=1",
                     f, OF, SF, ZF, CF, cout);
        end
        release_main();
        run_main(2'b01, 32'h0, 32'h1, 1'b0, lat);
        n_chk++;
        if ({f, OF, SF, CF, cout} !== {32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_borrow: f=%h OF=%b SF=%b CF=%b cout=%b required f=ffffffff OF=0 SF=1 CF=1 cout=0",
                     f, OF, SF, CF, cout);
        end
        release_main();
        run_main(2'b01, 32'h0, 32'h0, 1'b1, lat);
        n_chk++;
        if ({f, ZF, CF, cout} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_zero: f=%h ZF=%b CF=%b cout=%b required f=0 ZF=1 CF=0 cout=1", f, ZF, CF, cout);
        end
        release_main();
    endtask

    task automatic test_adc_sbb();
        int lat;
        logic [31:0] lo_f;
        logic        lo_cf;
        logic [63:0] ref64;
        run_main(2'b10, 32'h7FFF_FFFF, 32'h0, 1'b1, lat);
        n_chk++;
        if ({f, OF, SF, CF} !== {32'h8000_0000, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL adc_overflow: f=%h OF=%b SF=%b CF=%b required f=80000000 OF=1 SF=1 CF=0", f, OF, SF, CF);
        end
        release_main();
        run_main(2'b11, 32'h0, 32'h0, 1'b1, lat);
        n_chk++;
        if ({f, CF, ZF} !== {32'hFFFF_FFFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sbb_borrow: f=%h CF=%b ZF=%b required f=ffffffff CF=1 ZF=0", f, CF, ZF);
        end
        release_main();
        ref64 = 64'h0000_0001_FFFF_FFF0 + 64'h0000_0002_0000_0020;
        run_main(2'b00, 32'hFFFF_FFF0, 32'h0000_0020, 1'b0, lat);
        lo_f = f;
        lo_cf = CF;
        release_main();
        run_main(2'b10, 32'h0000_0001, 32'h0000_0002, lo_cf, lat);
        n_chk++;
        if ({f, lo_f} !== ref64) begin
            n_fail++;
            $display("FAIL chain64: got %h required %h", {f, lo_f}, ref64);
        end
        release_main();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] sv_f;
        // Operands change and in_valid stays high through RUN; result must be the accepted op.
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; x = 32'h10; y = 32'h20; cin = 1'b0;
        @(posedge clk);
        #1 x = 32'hDEAD_BEEF; y = 32'h1234_5678; op = 2'b01;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        n_chk++;
        if (lat != 4 || f !== 32'h30) begin
            n_fail++;
            $display("FAIL ignore_run: lat=%0d f=%h required lat=4 f=00000030", lat, f);
        end
        sv_f = f;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            x = $urandom; y = $urandom; op = 2'(i); in_valid = 1'b1;
            @(posedge clk);
            #1;
            n_chk++;
            if (f !== sv_f || {OF, SF, ZF, CF, cout} !== 5'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_done[%0d]: f=%h flags=%b rdy=%b vld=%b required f=%h flags=00000 rdy=0 vld=1",
                         i, f, {OF, SF, ZF, CF, cout}, in_ready, out_valid, sv_f);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_main();
        run_main(2'b01, 32'h0000_0100, 32'h0000_0001, 1'b0, lat);
        n_chk++;
        if (f !== 32'h0000_00FF || CF !== 1'b0 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL after_release: f=%h CF=%b cout=%b required f=000000ff CF=0 cout=1", f, CF, cout);
        end
        release_main();
    endtask

    task automatic test_single_chunk();
        int lat = 0;
        @(negedge clk);
        iv16 = 1'b1; op16 = 2'b00; x16 = 16'h7FFF; y16 = 16'h0001; cin16 = 1'b0;
        @(posedge clk);
        #1 iv16 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (ov16) begin
                lat = i;
                break;
            end
        end
        n_chk++;
        if (lat != 1 || f16 !== 16'h8000 || of16 !== 1'b1 || sf16 !== 1'b1 || cf16 !== 1'b0) begin
            n_fail++;
            $display("FAIL w16_add: lat=%0d f=%h OF=%b SF=%b CF=%b required lat=1 f=8000 OF=1 SF=1 CF=0",
                     lat, f16, of16, sf16, cf16);
        end
    endtask

    task automatic test_random12();
        logic [11:0] bb, ef;
        logic [12:0] s;
        logic        c0, eof, ecf, ecout;
        int          w, lat;
        for (int v = 0; v < 1000; v++) begin
            w = 0;
            @(negedge clk);
            while (!ir12 && w < 20) begin
                @(negedge clk);
                w++;
            end
            x12 = 12'($urandom); y12 = 12'($urandom); op12 = 2'($urandom); cin12 = 1'($urandom);
            if (v < 4) begin
                x12 = 12'hFFF; y12 = 12'h000; op12 = 2'(v); cin12 = 1'b1;
            end
            case (op12)
                2'b00: c0 = 1'b0;
                2'b01: c0 = 1'b1;
                2'b10: c0 = cin12;
                default: c0 = !cin12;
            endcase
            bb    = (op12 == 2'b01 || op12 == 2'b11) ? ~y12 : y12;
            s     = {1'b0, x12} + {1'b0, bb} + 13'(c0);
            ef    = s[11:0];
            ecout = s[12];
            ecf   = (op12 == 2'b01 || op12 == 2'b11) ? !ecout : ecout;
            eof   = (x12[11] == bb[11]) && (ef[11] != x12[11]);
            iv12 = 1'b1;
            @(posedge clk);
            #1 iv12 = 1'b0;
            lat = 0;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk);
                #1;
                if (ov12) begin
                    lat = i;
                    break;
                end
            end
            n_chk++;
            if (lat != 3 || w >= 20 || f12 !== ef || of12 !== eof || sf12 !== ef[11] ||
                zf12 !== (ef == 12'h0) || cf12 !== ecf || co12 !== ecout) begin
                n_fail++;
                $display("FAIL w12_vec[%0d]: op=%0d x=%h y=%h cin=%b lat=%0d f=%h OF%b SF%b ZF%b CF%b co%b required lat=3 f=%h OF%b SF%b ZF%b CF%b co%b",
                         v, op12, x12, y12, cin12, lat, f12, of12, sf12, zf12, cf12, co12,
                         ef, eof, ef[11], (ef == 12'h0), ecf, ecout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_reset_midrun();
        test_sub();
        test_adc_sbb();
        test_backpressure();
        test_single_chunk();
        test_random12();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
